// File: rtl/btb_predictor_if.sv
// Fetch/EX-side signal bundle for the branch target buffer: PC lookup,
// resolution updates, redirect and statistics.
interface btb_predictor_if;
    logic [31:0] if_pc;
    logic        btb_en;
    logic [31:0] pc_pre;

    // upd_valid qualifies all upd_* fields for exactly one cycle. There is no
    // ready: the predictor accepts every update in the cycle it is presented.
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;

    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    modport master (
        output if_pc, upd_valid, upd_pc, upd_taken, upd_target,
               upd_pred_taken, upd_pred_target,
        input  btb_en, pc_pre, mispredict, redirect_pc, branch_cnt, mispred_cnt
    );

    modport slave (
        input  if_pc, upd_valid, upd_pc, upd_taken, upd_target,
               upd_pred_taken, upd_pred_target,
        output btb_en, pc_pre, mispredict, redirect_pc, branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/btb_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters, trained from EX,
// plus misprediction detection, redirect PC and branch statistics.
module btb_predictor #(
    parameter int ENTRIES = 8,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic            clk,
    input  logic            rst,
    btb_predictor_if.slave  bus
);
    localparam int TAG_W = 30 - IDX_W;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];
    logic [31:0]      branch_cnt_q;
    logic [31:0]      mispred_cnt_q;

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic             mispredict;
    logic             unused_pc_bits;

    // Word-aligned PCs: bits [1:0] never take part in index or tag.
    assign unused_pc_bits = ^{bus.if_pc[1:0], bus.upd_pc[1:0]};

    assign lk_idx = bus.if_pc[IDX_W+1:2];
    assign lk_tag = bus.if_pc[31:IDX_W+2];
    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

    assign bus.btb_en = lk_hit && ctr_q[lk_idx][1];
    assign bus.pc_pre = bus.btb_en ? target_q[lk_idx] : 32'd0;

    assign up_idx = bus.upd_pc[IDX_W+1:2];
    assign up_tag = bus.upd_pc[31:IDX_W+2];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    assign mispredict = bus.upd_valid &&
                        ((bus.upd_taken != bus.upd_pred_taken) ||
                         (bus.upd_taken && bus.upd_pred_taken &&
                          (bus.upd_target != bus.upd_pred_target)));

    assign bus.mispredict  = mispredict;
    assign bus.redirect_pc = bus.upd_taken ? bus.upd_target : bus.upd_pc + 32'd4;
    assign bus.branch_cnt  = branch_cnt_q;
    assign bus.mispred_cnt = mispred_cnt_q;

    // Tags and targets are only meaningful behind a valid bit, so reset leaves them alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b01;
            end
            branch_cnt_q  <= 32'd0;
            mispred_cnt_q <= 32'd0;
        end else if (bus.upd_valid) begin
            branch_cnt_q <= branch_cnt_q + 32'd1;
            if (mispredict) begin
                mispred_cnt_q <= mispred_cnt_q + 32'd1;
            end
            if (up_hit) begin
                if (bus.upd_taken) begin
                    target_q[up_idx] <= bus.upd_target;
                    if (ctr_q[up_idx] != 2'b11) begin
                        ctr_q[up_idx] <= ctr_q[up_idx] + 2'd1;
                    end
                end else if (ctr_q[up_idx] != 2'b00) begin
                    ctr_q[up_idx] <= ctr_q[up_idx] - 2'd1;
                end
            end else if (bus.upd_taken) begin
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= bus.upd_target;
                ctr_q[up_idx]    <= 2'b10;
            end
        end
    end
endmodule
